// File: rtl/fifo_reader.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_reader
//  Purpose  : Read-side master for a FIFO with a 1-cycle registered read
//             latency. It issues reads, holds returning words in a 2-entry
//             skid buffer, and presents them as a valid/ready stream. It also
//             counts the words accepted downstream.
//  Ports    : clk        - clock, all state on the rising edge
//             rstn       - asynchronous reset, active low
//             en         - read enable; 0 stops new FIFO reads
//             clr        - synchronous clear of count (wins over a pop)
//             fifo_empty - FIFO empty flag
//             fifo_data  - FIFO data_out, valid the cycle after a read
//             fifo_rd_en - FIFO read enable (combinational)
//             m_valid    - stream word valid (registered)
//             m_ready    - downstream accepts the word
//             m_data     - stream word (head of buffer, registered)
//             count      - words accepted since reset/clr, wraps
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_reader #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             en,
   input  logic             clr,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_data,
   output logic             fifo_rd_en,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic [CNT_W-1:0] count
);

   // Buffer state: ent0 is always the head, ent1 the second word.
   logic [1:0]       occ_q,   occ_d;
   logic             pend_q;
   logic [WIDTH-1:0] ent0_q,  ent0_d;
   logic [WIDTH-1:0] ent1_q,  ent1_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic             pop;
   logic [2:0]       inflight;
   logic [1:0]       occ_after_pop;

   always_comb begin
      pop = valid_q & m_ready;

      // Words that will be held or in flight after this cycle's pop.
      // A pop implies occ_q >= 1, so the subtraction cannot underflow.
      inflight = {1'b0, occ_q} + {2'b00, pend_q} - {2'b00, pop};

      // rstn is folded in so no read can escape while the block is in reset.
      fifo_rd_en = rstn & en & ~fifo_empty & (inflight < 3'd2);

      occ_after_pop = occ_q - {1'b0, pop};

      ent0_d = ent0_q;
      ent1_d = ent1_q;
      if (pop) begin
         ent0_d = ent1_q;
      end
      // The arriving word lands at the first free slot after the pop shift.
      if (pend_q) begin
         if (occ_after_pop == 2'd0) begin
            ent0_d = fifo_data;
         end else begin
            ent1_d = fifo_data;
         end
      end

      occ_d   = occ_after_pop + {1'b0, pend_q};
      valid_d = (occ_d != 2'd0);

      if (clr) begin
         count_d = '0;
      end else begin
         count_d = count_q + {{(CNT_W-1){1'b0}}, pop};
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         occ_q   <= 2'd0;
         pend_q  <= 1'b0;
         ent0_q  <= '0;
         ent1_q  <= '0;
         valid_q <= 1'b0;
         count_q <= '0;
      end else begin
         occ_q   <= occ_d;
         pend_q  <= fifo_rd_en;
         ent0_q  <= ent0_d;
         ent1_q  <= ent1_d;
         valid_q <= valid_d;
         count_q <= count_d;
      end
   end

   assign m_valid = valid_q;
   assign m_data  = ent0_q;
   assign count   = count_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_reader
//  Purpose  : Self-checking bench for fifo_reader. A behavioural FIFO with
//             1-cycle read latency feeds the DUT; every pushed word is also
//             queued as an expected stream word and compared on each pop.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_reader;

   localparam int WIDTH = 8;
   localparam int CNT_W = 16;
   localparam int DEPTH = 1024;

   logic             clk;
   logic             rstn;
   logic             en;
   logic             clr;
   logic             fifo_empty;
   logic [WIDTH-1:0] fifo_data;
   logic             fifo_rd_en;
   logic             m_valid;
   logic             m_ready;
   logic [WIDTH-1:0] m_data;
   logic [CNT_W-1:0] count;

   int checks = 0;
   int errors = 0;

   // Behavioural FIFO
   logic [WIDTH-1:0] mem [0:DEPTH-1];
   int               wr_ptr = 0;
   int               rd_ptr = 0;

   // Scoreboard and outstanding-word tracking
   logic [WIDTH-1:0] sb [$];
   int               reads = 0;
   int               pops  = 0;

   fifo_reader #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .en         (en),
      .clr        (clr),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_rd_en (fifo_rd_en),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .count      (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign fifo_empty = (wr_ptr == rd_ptr);

   initial fifo_data = '0;
   always @(posedge clk) begin
      if (fifo_rd_en) begin
         fifo_data <= mem[rd_ptr % DEPTH];
         rd_ptr    <= rd_ptr + 1;
      end
   end

   // Stream monitor: in-order data check, no read when empty, occ+pend <= 2.
   always @(negedge clk) begin
      if (rstn) begin
         checks++;
         assert ((reads - pops) <= 2) else begin
            errors++;
            $error("FAIL outstanding observed=%0d expected<=2", reads - pops);
         end
         checks++;
         assert (!(fifo_rd_en && fifo_empty)) else begin
            errors++;
            $error("FAIL rd_when_empty observed=1 expected=0");
         end
         if (fifo_rd_en) reads++;
         if (m_valid && m_ready) begin
            pops++;
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $error("FAIL extra_word observed=%0h expected=none", m_data);
            end else begin
               logic [WIDTH-1:0] exp_w;
               exp_w = sb.pop_front();
               assert (m_data === exp_w) else begin
                  errors++;
                  $error("FAIL m_data observed=%0h expected=%0h", m_data, exp_w);
               end
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [WIDTH-1:0] w);
      mem[wr_ptr % DEPTH] = w;
      wr_ptr = wr_ptr + 1;
      sb.push_back(w);
   endtask

   task automatic drain(input string tag, input int budget);
      int n;
      n = 0;
      while (sb.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      chk(tag, sb.size(), 0);
   endtask

   initial begin
      int rdcnt;
      rstn    = 1'b0;
      en      = 1'b1;
      clr     = 1'b0;
      m_ready = 1'b1;

      // ---- Reset with a non-empty FIFO, then streaming at full rate ----
      tick();
      for (int i = 0; i < 8; i++) push_word(8'h11 + i[7:0]);
      tick();
      @(negedge clk);
      chk("rst_rd_en",  {31'd0, fifo_rd_en}, 0);
      chk("rst_valid",  {31'd0, m_valid},    0);
      chk("rst_count",  {16'd0, count},      0);
      chk("rst_data",   {24'd0, m_data},     0);
      @(posedge clk);
      #1 rstn = 1'b1;
      @(negedge clk);
      chk("first_rd_en", {31'd0, fifo_rd_en}, 1);
      chk("valid_c0",    {31'd0, m_valid},    0);
      tick();
      @(negedge clk);
      chk("valid_c1",    {31'd0, m_valid},    0);
      for (int k = 0; k < 8; k++) begin
         tick();
         @(negedge clk);
         chk($sformatf("stream_valid%0d", k), {31'd0, m_valid}, 1);
      end
      tick();
      @(negedge clk);
      chk("stream_end_valid", {31'd0, m_valid}, 0);
      chk("stream_count",     {16'd0, count},   8);

      // ---- Backpressure: 10-cycle stall then drain ----
      tick();
      m_ready = 1'b0;
      clr     = 1'b1;
      tick();
      clr = 1'b0;
      for (int i = 0; i < 8; i++) push_word(8'h11 + i[7:0]);
      chk("clr_count", {16'd0, count}, 0);
      rdcnt = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (fifo_rd_en) rdcnt++;
         tick();
      end
      chk("stall_reads", rdcnt, 2);
      @(negedge clk);
      chk("stall_valid", {31'd0, m_valid}, 1);
      chk("stall_hold",  {24'd0, m_data},  32'h11);
      tick();
      m_ready = 1'b1;
      drain("stall_drain", 100);
      chk("stall_count", {16'd0, count}, 8);

      // ---- en dropped right after a read is issued ----
      tick();
      push_word(8'h21);
      push_word(8'h22);
      push_word(8'h23);
      @(negedge clk);
      chk("en_first_rd", {31'd0, fifo_rd_en}, 1);
      tick();
      en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("en_off_rd%0d", k), {31'd0, fifo_rd_en}, 0);
         tick();
      end
      chk("en_inflight_delivered", sb.size(), 2);
      en = 1'b1;
      drain("en_drain", 100);

      // ---- Random backpressure over 200 random words ----
      for (int i = 0; i < 200; i++) push_word(WIDTH'($urandom));
      begin
         int n;
         n = 0;
         while (sb.size() != 0 && n < 3000) begin
            m_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
         end
      end
      chk("rand_drain", sb.size(), 0);
      m_ready = 1'b1;

      // ---- Counter wrap ----
      clr = 1'b1;
      tick();
      clr = 1'b0;
      for (int i = 0; i < 65535; i++) begin
         push_word(i[7:0]);
         tick();
      end
      drain("wrap_drain", 100);
      chk("count_max", {16'd0, count}, 32'hFFFF);
      push_word(8'h5A);
      drain("wrap_drain2", 100);
      chk("count_wrap", {16'd0, count}, 0);

      // ---- clr coincident with a pop ----
      m_ready = 1'b0;
      push_word(8'h31);
      push_word(8'h32);
      for (int k = 0; k < 4; k++) tick();
      @(negedge clk);
      chk("clr_pre_valid", {31'd0, m_valid}, 1);
      tick();
      m_ready = 1'b1;
      clr     = 1'b1;
      tick();
      clr = 1'b0;
      @(negedge clk);
      chk("clr_with_pop", {16'd0, count}, 0);
      tick();
      @(negedge clk);
      chk("count_after_clr", {16'd0, count}, 1);
      drain("final_drain", 100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
